mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage load/store unit of the pipelined ARMv8 core. Takes the address (`alu_result`) and store data from EX/MEM and runs a variable-latency req/ack transaction to data memory. Handles byte lanes and sign/zero extension for LDUR/LDURB/LDURH/LDURSW/STUR*, and stalls the pipeline until the access completes. Its `read_data_out`/`alu_result_out` drive the `read_data_in`/`alu_result_in` inputs of the MEM/WB register.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width (fixed 64; 8 byte lanes)
- `clock  in  1`  rising-edge clock
- `reset  in  1`  synchronous, active-high reset
- `mem_read  in  1`  load in EX/MEM
- `mem_write  in  1`  store in EX/MEM
- `size  in  2`  access size: 00 byte, 01 half, 10 word, 11 dword
- `sign_ext  in  1`  sign-extend load result (ignored for dword and stores)
- `alu_result_in  in  64`  effective address / ALU result
- `write_data_in  in  64`  store data, right-aligned
- `dmem_req  out  1`  memory request
- `dmem_we  out  1`  1 = write
- `dmem_addr  out  64`  dword-aligned address (`alu_result_in` with [2:0] = 0)
- `dmem_wdata  out  64`  lane-shifted store data
- `dmem_be  out  8`  byte enables
- `dmem_ack  in  1`  one-cycle completion pulse from memory
- `dmem_rdata  in  64`  read data, valid with `dmem_ack`
- `read_data_out  out  64`  extended load result, to MEM/WB
- `alu_result_out  out  64`  ALU result, to MEM/WB
- `stall  out  1`  freeze IF..EX/MEM this cycle
- `misaligned  out  1`  alignment fault pulse

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, no memory op: `stall`=0; `alu_result_out` = `alu_result_in` (combinational); `read_data_out` = held register.
- IDLE, op present and aligned: `stall`=1 combinationally. Latch address, size, sign_ext, direction, be and wdata. Go to WAIT.
- Alignment rule: address must be a multiple of 2^`size`. Misaligned op in IDLE:
  - `misaligned`=1 for that cycle, `stall`=0, no request.
  - Read-data register cleared to 0; state stays IDLE.
- WAIT:
  - `dmem_req`=1 with `dmem_we`/addr/wdata/be stable until `dmem_ack`; `stall`=1; `alu_result_out` = latched address.
  - On `dmem_ack`: for loads, capture the extended `dmem_rdata`; for stores, clear the read-data register to 0. Go to DONE.
- DONE:
  - `stall`=0; outputs show the latched result; MEM/WB captures at the end of this cycle.
  - Inputs are ignored, because EX/MEM still holds the same instruction.
  - Unconditional transition to IDLE.
- `mem_read` and `mem_write` both high: treated as a store.
- `dmem_ack` outside WAIT: ignored.
- Lanes are little-endian, with lane offset `a` = addr[2:0]:
  - `dmem_be`: byte `1<<a`, half `3<<a`, word `F<<a`, dword `FF`.
  - `dmem_wdata` = `write_data_in << 8a`.
  - Load: `dmem_rdata >> 8a`, truncate to size, then sign- or zero-extend to 64.
- Reset (any state): next cycle state = IDLE and all outputs return to reset values. An ack still in flight from before reset is ignored.

## Timing
- Reset values: `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be`, `read_data_out`, `misaligned` = 0. `stall` = 0 once in IDLE with no op. `alu_result_out` follows `alu_result_in`.
- `dmem_req` is registered: first asserted in the cycle after the op is seen in IDLE.
- Latency with ack after N WAIT cycles (N ≥ 1): op cycle C0 (IDLE) → WAIT C1..CN, ack in CN → DONE CN+1 → IDLE CN+2.
  - `stall` is high C0..CN, N+1 cycles.
  - Minimum is one stall-free result every 3 cycles per memory op.
- Non-memory ops and misaligned ops: zero added latency.

## Structure
- Shared package `arm_mem_pkg` holds:
  - Size encodings `SZ_B`/`SZ_H`/`SZ_W`/`SZ_D`.
  - FSM state enum.
  - Byte-enable lookup function.
- Sub-module `mem_lane_align`, purely combinational:
  - Inputs: offset, size, sign_ext, wdata, rdata.
  - Outputs: be, shifted wdata, extended rdata.
  - Shared by the FSM for store and load paths.

## Test plan
- LDUR dword at 0x100, memory returns 0x1122334455667788 after 1 WAIT cycle → `dmem_addr`=0x100, `be`=FF, stall 2 cycles, `read_data_out`=0x1122334455667788 in DONE.
- LDURSW, address 0x104, `sign_ext`=1, `rdata`=0x80000001_00000000 → `be`=F0, `read_data_out`=0xFFFFFFFF80000001.
- STURB of 0xAB to 0x103 → `dmem_we`=1, `be`=08, `wdata`[31:24]=0xAB, `read_data_out`=0 in DONE.
- LDURH at 0x101 → `misaligned`=1 for one cycle, `dmem_req` never asserted, `stall`=0.
- Ack delayed 5 cycles → req/addr/be held stable for all 5 cycles, stall 6 cycles. ADD in IDLE before the op → `alu_result_out` passes through in the same cycle.
- Assert reset in the second WAIT cycle, then a late ack → `dmem_req`=0 the next cycle, state IDLE, ack ignored, `read_data_out`=0.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access sizes, FSM states
// and the byte-lane helpers used by both the FSM and the lane aligner.
package arm_mem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mau_state_e;

   function automatic logic [7:0] byte_enables(input logic [1:0] size, input logic [2:0] offset);
      logic [7:0] mask;
      case (size)
         SZ_B:    mask = 8'h01;
         SZ_H:    mask = 8'h03;
         SZ_W:    mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      return mask << offset;
   endfunction

   // An access is aligned when the low address bits below its size are all zero.
   function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] offset);
      case (size)
         SZ_B:    return 1'b1;
         SZ_H:    return offset[0] == 1'b0;
         SZ_W:    return offset[1:0] == 2'b00;
         default: return offset == 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: byte enables and shifted store data on the
// way out, right-aligned and sign/zero-extended load data on the way back.
module mem_lane_align
   import arm_mem_pkg::*;
(
   input  logic [2:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata,
   output logic [7:0]  be,
   output logic [63:0] wdata_shifted,
   output logic [63:0] rdata_extended
);

   logic [63:0] rdata_shifted;

   always_comb begin
      be             = byte_enables(size, offset);
      wdata_shifted  = wdata << {offset, 3'b000};
      rdata_shifted  = rdata >> {offset, 3'b000};
      rdata_extended = rdata_shifted;
      case (size)
         SZ_B: rdata_extended = {{56{sign_ext & rdata_shifted[7]}},  rdata_shifted[7:0]};
         SZ_H: rdata_extended = {{48{sign_ext & rdata_shifted[15]}}, rdata_shifted[15:0]};
         SZ_W: rdata_extended = {{32{sign_ext & rdata_shifted[31]}}, rdata_shifted[31:0]};
         default: rdata_extended = rdata_shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one req/ack data-memory transaction per memory
// op, stalls the front of the pipeline meanwhile and hands the result to MEM/WB.
module mem_access_unit
   import arm_mem_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] write_data_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [7:0]        dmem_be,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [DATA_W-1:0] read_data_out,
   output logic [ADDR_W-1:0] alu_result_out,
   output logic              stall,
   output logic              misaligned
);

   mau_state_e        state;
   logic [ADDR_W-1:0] lat_addr;
   logic [1:0]        lat_size;
   logic              lat_sign;
   logic              lat_store;

   logic              in_idle;
   logic              mem_op;
   logic              op_aligned;
   logic [2:0]        lane_offset;
   logic [1:0]        lane_size;
   logic              lane_sign;
   logic [7:0]        lane_be;
   logic [DATA_W-1:0] lane_wdata;
   logic [DATA_W-1:0] lane_rdata;

   assign in_idle    = (state == IDLE);
   assign mem_op     = mem_read | mem_write;
   assign op_aligned = is_aligned(size, alu_result_in[2:0]);

   // One aligner serves both directions: live inputs while issuing from IDLE,
   // the latched access while waiting for the load data to come back.
   assign lane_offset = in_idle ? alu_result_in[2:0] : lat_addr[2:0];
   assign lane_size   = in_idle ? size : lat_size;
   assign lane_sign   = in_idle ? sign_ext : lat_sign;

   mem_lane_align u_lane_align (
      .offset         (lane_offset),
      .size           (lane_size),
      .sign_ext       (lane_sign),
      .wdata          (write_data_in),
      .rdata          (dmem_rdata),
      .be             (lane_be),
      .wdata_shifted  (lane_wdata),
      .rdata_extended (lane_rdata)
   );

   assign stall          = (state == WAIT) | (in_idle & mem_op & op_aligned);
   assign misaligned     = in_idle & mem_op & ~op_aligned;
   assign alu_result_out = in_idle ? alu_result_in : lat_addr;

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         lat_addr      <= '0;
         lat_size      <= SZ_B;
         lat_sign      <= 1'b0;
         lat_store     <= 1'b0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         dmem_be       <= '0;
         read_data_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op && op_aligned) begin
                  lat_addr   <= alu_result_in;
                  lat_size   <= size;
                  lat_sign   <= sign_ext;
                  lat_store  <= mem_write;
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write;
                  dmem_addr  <= {alu_result_in[ADDR_W-1:3], 3'b000};
                  dmem_wdata <= lane_wdata;
                  dmem_be    <= lane_be;
                  state      <= WAIT;
               end else if (mem_op) begin
                  read_data_out <= '0;
               end
            end
            WAIT: begin
               if (dmem_ack) begin
                  dmem_req      <= 1'b0;
                  read_data_out <= lat_store ? '0 : lane_rdata;
                  state         <= DONE;
               end
            end
            DONE: begin
               // EX/MEM still holds the finished instruction here, so its inputs are ignored.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized ops
// compared against a byte-lane reference model written with plain arithmetic.
module tb_mem_access_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  size;
   logic        sign_ext;
   logic [63:0] alu_result_in;
   logic [63:0] write_data_in;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_be;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;
   logic [63:0] read_data_out;
   logic [63:0] alu_result_out;
   logic        stall;
   logic        misaligned;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] rd_model = '0;

   mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
      .clock          (clock),
      .reset          (reset),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .size           (size),
      .sign_ext       (sign_ext),
      .alu_result_in  (alu_result_in),
      .write_data_in  (write_data_in),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_be        (dmem_be),
      .dmem_ack       (dmem_ack),
      .dmem_rdata     (dmem_rdata),
      .read_data_out  (read_data_out),
      .alu_result_out (alu_result_out),
      .stall          (stall),
      .misaligned     (misaligned)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic sx, input logic [63:0] addr, input logic [63:0] wd);
      mem_read      = rd;
      mem_write     = wr;
      size          = sz;
      sign_ext      = sx;
      alu_result_in = addr;
      write_data_in = wd;
      dmem_ack      = 1'b0;
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // Reference: what the load result must be for a given lane and size.
   function automatic logic [63:0] modelLoad(input logic [63:0] rdat, input logic [2:0] off,
                                             input logic [1:0] sz, input logic sx);
      logic [63:0] tmp, mask, res;
      int nb;
      tmp = rdat >> (8 * off);
      if (sz == 2'd3) return tmp;
      nb   = 8 << sz;
      mask = (64'd1 << nb) - 64'd1;
      res  = tmp & mask;
      if (sx && tmp[nb-1]) res = res | ~mask;
      return res;
   endfunction

   function automatic logic [7:0] modelBe(input logic [2:0] off, input logic [1:0] sz);
      logic [7:0] be;
      be = '0;
      for (int b = 0; b < (1 << sz); b++) be[off + b] = 1'b1;
      return be;
   endfunction

   // One instruction through the MEM stage, starting at a negedge in IDLE.
   task automatic runOp(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rdat,
                        input int nwait);
      logic        op, al;
      logic [2:0]  off;
      logic [63:0] ld;
      op  = rd | wr;
      off = addr[2:0];
      al  = (addr % (64'd1 << sz)) == 64'd0;
      @(negedge clock);
      applyStimulus(rd, wr, sz, sx, addr, wd);
      if (!op) dmem_ack = 1'($urandom_range(0, 1));
      dmem_rdata = rand64();
      #1;
      checkOutput("c0_req", dmem_req, 0);
      checkOutput("c0_alu_out", alu_result_out, addr);
      checkOutput("c0_rdata", read_data_out, rd_model);
      if (!op) begin
         checkOutput("nop_stall", stall, 0);
         checkOutput("nop_misaligned", misaligned, 0);
      end else if (!al) begin
         checkOutput("mis_flag", misaligned, 1);
         checkOutput("mis_stall", stall, 0);
         rd_model = '0;
         @(negedge clock);
         applyStimulus(0, 0, 0, 0, rand64(), rand64());
         #1;
         checkOutput("mis_req", dmem_req, 0);
         checkOutput("mis_rdata", read_data_out, 0);
         checkOutput("mis_flag_clear", misaligned, 0);
      end else begin
         checkOutput("c0_stall", stall, 1);
         checkOutput("c0_misaligned", misaligned, 0);
         ld = modelLoad(rdat, off, sz, sx);
         for (int i = 1; i <= nwait; i++) begin
            @(negedge clock);
            dmem_ack   = (i == nwait);
            dmem_rdata = (i == nwait) ? rdat : rand64();
            #1;
            checkOutput("wait_req", dmem_req, 1);
            checkOutput("wait_we", dmem_we, wr);
            checkOutput("wait_addr", dmem_addr, {addr[63:3], 3'b000});
            checkOutput("wait_be", dmem_be, modelBe(off, sz));
            checkOutput("wait_wdata", dmem_wdata, wd << (8 * off));
            checkOutput("wait_stall", stall, 1);
            checkOutput("wait_alu_out", alu_result_out, addr);
         end
         rd_model = wr ? 64'd0 : ld;
         @(negedge clock);
         applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), rand64(), rand64());
         #1;
         checkOutput("done_stall", stall, 0);
         checkOutput("done_misaligned", misaligned, 0);
         checkOutput("done_rdata", read_data_out, rd_model);
         checkOutput("done_alu_out", alu_result_out, addr);
         checkOutput("done_req", dmem_req, 0);
      end
   endtask

   initial begin
      applyStimulus(0, 0, 0, 0, 64'h0, 64'h0);
      dmem_rdata = '0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      alu_result_in = 64'hDEAD_BEEF_0000_0042;
      #1;
      checkOutput("rst_req", dmem_req, 0);
      checkOutput("rst_we", dmem_we, 0);
      checkOutput("rst_addr", dmem_addr, 0);
      checkOutput("rst_wdata", dmem_wdata, 0);
      checkOutput("rst_be", dmem_be, 0);
      checkOutput("rst_rdata", read_data_out, 0);
      checkOutput("rst_misaligned", misaligned, 0);
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_alu_out", alu_result_out, 64'hDEAD_BEEF_0000_0042);
      reset = 1'b0;

      runOp(0, 0, 2'd3, 0, 64'h0000_0000_0000_1234, 64'h0, 64'h0, 1);
      runOp(1, 0, 2'd3, 0, 64'h100, 64'h0, 64'h1122334455667788, 1);
      runOp(1, 0, 2'd2, 1, 64'h104, 64'h0, 64'h80000001_00000000, 2);
      runOp(0, 1, 2'd0, 0, 64'h103, 64'hAB, 64'h0, 1);
      runOp(1, 0, 2'd1, 0, 64'h101, 64'h0, 64'hFFFF, 1);
      runOp(0, 0, 2'd0, 0, 64'h0000_0000_0000_0777, 64'h0, 64'h0, 1);
      runOp(1, 0, 2'd1, 1, 64'h206, 64'h0, 64'h8123_4567_89AB_CDEF, 5);
      runOp(1, 1, 2'd2, 0, 64'h300, 64'hCAFE_F00D, 64'h5555, 3);
      runOp(1, 0, 2'd0, 0, 64'h407, 64'h0, 64'hF0E1_D2C3_B4A5_9687, 1);

      for (int n = 0; n < 80; n++) begin
         logic [63:0] a;
         logic [1:0]  sz;
         sz = 2'($urandom);
         a  = rand64();
         if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
         runOp(1'($urandom), 1'($urandom), sz, 1'($urandom), a, rand64(), rand64(),
               int'($urandom_range(1, 4)));
      end

      // Reset in the middle of a transaction, then an ack that arrives too late.
      runOp(1, 0, 2'd3, 0, 64'h500, 64'h0, 64'h0123_4567_89AB_CDEF, 1);
      @(negedge clock);
      applyStimulus(1, 0, 2'd3, 0, 64'h600, 64'h0);
      @(negedge clock);
      #1;
      checkOutput("rstmid_req_w1", dmem_req, 1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 64'h0000_0000_0000_0ABC, 64'h0);
      dmem_ack   = 1'b1;
      dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      rd_model   = '0;
      #1;
      checkOutput("rstmid_req", dmem_req, 0);
      checkOutput("rstmid_stall", stall, 0);
      checkOutput("rstmid_rdata", read_data_out, 0);
      checkOutput("rstmid_alu_out", alu_result_out, 64'h0ABC);
      @(negedge clock);
      dmem_ack = 1'b0;
      #1;
      checkOutput("late_ack_rdata", read_data_out, 0);
      checkOutput("late_ack_req", dmem_req, 0);
      runOp(1, 0, 2'd2, 0, 64'h708, 64'h0, 64'h1234_5678_9ABC_DEF0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
